// File: rtl/change_key_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : change_key_ctrl_if
//  Purpose  : Bundles the push-button input and the cleaned press outputs of
//             change_key_ctrl so that the board side and the controller side
//             connect through one port.
//  Signals  : key_in      - raw push-button, asynchronous, bouncing
//             change      - single-cycle press pulse toward traffic_ctr
//             key_level   - debounced key state, 1 = pressed
//             busy        - high while the cooldown window is running
//             press_count - number of pulses issued, wraps 255 -> 0
//  Modports : master - drives key_in, observes the outputs (board / bench)
//             slave  - receives key_in, drives the outputs (change_key_ctrl)
//  Revision : 1.0 - initial release
// ============================================================================
interface change_key_ctrl_if;
  logic       key_in;
  logic       change;
  logic       key_level;
  logic       busy;
  logic [7:0] press_count;

  modport master (
    output key_in,
    input  change,
    input  key_level,
    input  busy,
    input  press_count
  );

  modport slave (
    input  key_in,
    output change,
    output key_level,
    output busy,
    output press_count
  );
endinterface
`default_nettype wire

// File: rtl/change_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : change_key_ctrl
//  Purpose  : Turns a raw, bouncing push-button into one clean single-cycle
//             `change` pulse per physical press. The key is synchronised,
//             debounced, edge-detected and then gated by a cooldown window.
//  Ports    : clk   - system clock (50 MHz)
//             reset - synchronous, active-high reset
//             bus   - change_key_ctrl_if.slave:
//                       key_in (in), change, key_level, busy,
//                       press_count[7:0] (out)
//  Params   : DEBOUNCE_CYCLES - stable cycles before key_level follows (>=1)
//             COOLDOWN_CYCLES - cycles after a pulse that ignore presses (>=1)
//             CNT_W           - counter width; both cycle params < 2**CNT_W
//             ACTIVE_LOW_KEY  - 1: key_in reads 0 when pressed
//  Revision : 1.0 - initial release
// ============================================================================
module change_key_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int COOLDOWN_CYCLES = 25000000,
  parameter int CNT_W           = 25,
  parameter int ACTIVE_LOW_KEY  = 1
) (
  input  logic               clk,
  input  logic               reset,
  change_key_ctrl_if.slave   bus
);

  // Level that key_in shows when the button is not pressed.
  localparam logic             KEY_RELEASED = (ACTIVE_LOW_KEY != 0);
  localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD    = CNT_W'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_COOLDOWN     = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] db_cnt_q,        db_cnt_d;
  logic             key_level_q,     key_level_d;
  logic             key_level_dly_q;
  state_t           state_q,         state_d;
  logic [CNT_W-1:0] cd_cnt_q,        cd_cnt_d;
  logic             change_q,        change_d;
  logic             busy_q,          busy_d;
  logic [7:0]       press_count_q,   press_count_d;

  logic             pressed_raw;
  logic             rise;

  // Normalised so that 1 always means "pressed", whatever the key polarity.
  assign pressed_raw = sync2_q ^ KEY_RELEASED;
  assign rise        = key_level_q & ~key_level_dly_q;

  // --------------------------------------------------------------------------
  // Debounce: key_level only follows pressed_raw after it has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles; any return to agreement restarts.
  // --------------------------------------------------------------------------
  always_comb begin
    db_cnt_d    = '0;
    key_level_d = key_level_q;
    if (pressed_raw != key_level_q) begin
      if (db_cnt_q == DEB_LAST) begin
        key_level_d = pressed_raw;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Press FSM: one pulse per debounced rising edge, then a cooldown, then
  // (if the key is still held) a wait for release so a long hold cannot
  // produce a second pulse.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cd_cnt_d      = cd_cnt_q;
    change_d      = 1'b0;
    press_count_d = press_count_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          change_d      = 1'b1;
          press_count_d = press_count_q + 8'd1;
          cd_cnt_d      = COOL_LOAD;
          state_d       = ST_COOLDOWN;
        end
      end

      ST_COOLDOWN: begin
        if (cd_cnt_q == '0) begin
          state_d = key_level_q ? ST_WAIT_RELEASE : ST_IDLE;
        end else begin
          cd_cnt_d = cd_cnt_q - 1'b1;
        end
      end

      ST_WAIT_RELEASE: begin
        if (!key_level_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy is registered from the next state so it rises together with
    // change and stays up for exactly COOLDOWN_CYCLES cycles.
    busy_d = (state_d == ST_COOLDOWN);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q         <= KEY_RELEASED;
      sync2_q         <= KEY_RELEASED;
      db_cnt_q        <= '0;
      key_level_q     <= 1'b0;
      key_level_dly_q <= 1'b0;
      state_q         <= ST_IDLE;
      cd_cnt_q        <= '0;
      change_q        <= 1'b0;
      busy_q          <= 1'b0;
      press_count_q   <= 8'd0;
    end else begin
      sync1_q         <= bus.key_in;
      sync2_q         <= sync1_q;
      db_cnt_q        <= db_cnt_d;
      key_level_q     <= key_level_d;
      key_level_dly_q <= key_level_q;
      state_q         <= state_d;
      cd_cnt_q        <= cd_cnt_d;
      change_q        <= change_d;
      busy_q          <= busy_d;
      press_count_q   <= press_count_d;
    end
  end

  assign bus.change      = change_q;
  assign bus.key_level   = key_level_q;
  assign bus.busy        = busy_q;
  assign bus.press_count = press_count_q;

endmodule
`default_nettype wire

// File: tb/tb_change_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_change_key_ctrl
//  Purpose  : Self-checking bench for change_key_ctrl with DEBOUNCE_CYCLES=4,
//             COOLDOWN_CYCLES=8, active-low key. A behavioural model predicts
//             all outputs every cycle; directed scenarios add literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_change_key_ctrl;

  localparam int DEB  = 4;
  localparam int COOL = 8;

  logic clk;
  logic reset;

  change_key_ctrl_if u_if ();

  change_key_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .COOLDOWN_CYCLES (COOL),
    .CNT_W           (8),
    .ACTIVE_LOW_KEY  (1)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model. Debounce is judged on a sliding window of the last
  // DEB synchronised samples; cooldown is a count of busy cycles left.
  // --------------------------------------------------------------------------
  bit   m_valid = 0;
  bit   m_s1, m_s2;
  bit   q_raw[$];
  bit   m_lvl, m_lvl_prev;
  int   m_cd;
  bit   m_wait;
  bit   m_change;
  int   m_cnt;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      q_raw.delete();
      m_lvl = 0; m_lvl_prev = 0;
      m_cd = 0; m_wait = 0; m_change = 0; m_cnt = 0;
      m_valid = 1;
    end else begin
      bit raw, lvl_old, prev_old, all_diff, rise;
      raw      = ~m_s2;
      lvl_old  = m_lvl;
      prev_old = m_lvl_prev;
      q_raw.push_back(raw);
      if (q_raw.size() > DEB) void'(q_raw.pop_front());
      all_diff = (q_raw.size() == DEB);
      foreach (q_raw[i]) if (q_raw[i] == lvl_old) all_diff = 0;
      if (all_diff) begin
        m_lvl = ~lvl_old;
        q_raw.delete();
      end
      m_lvl_prev = lvl_old;
      m_s2 = m_s1;
      m_s1 = u_if.key_in;

      rise     = lvl_old & ~prev_old;
      m_change = 0;
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) m_wait = lvl_old;
      end else if (m_wait) begin
        if (!lvl_old) m_wait = 0;
      end else if (rise) begin
        m_change = 1;
        m_cnt    = (m_cnt + 1) % 256;
        m_cd     = COOL;
      end
    end
  end

  // Compare process: outputs are registered, so mid-cycle is safe.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_change",      int'(u_if.change),      int'(m_change));
      chk("model_busy",        int'(u_if.busy),        int'(m_cd > 0));
      chk("model_key_level",   int'(u_if.key_level),   int'(m_lvl));
      chk("model_press_count", int'(u_if.press_count), m_cnt);
    end
    if (u_if.change) pulse_cnt++;
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    u_if.key_in = 1'b1;
    cyc(2);
    chk("rst_change",      int'(u_if.change),      0);
    chk("rst_busy",        int'(u_if.busy),        0);
    chk("rst_key_level",   int'(u_if.key_level),   0);
    chk("rst_press_count", int'(u_if.press_count), 0);
    reset = 1'b0;
  endtask

  task automatic hold(input logic k, input int n);
    u_if.key_in = k;
    cyc(n);
  endtask

  int p0;

  initial begin
    reset = 1'b1;
    u_if.key_in = 1'b1;

    // 1. Clean press with hand-counted timing
    do_reset();
    p0 = pulse_cnt;
    u_if.key_in = 1'b0;
    cyc(5);
    chk("t1_level_before", int'(u_if.key_level), 0);
    cyc(1);
    chk("t1_level_rise",   int'(u_if.key_level), 1);
    chk("t1_change_early", int'(u_if.change),    0);
    cyc(1);
    chk("t1_change_high",  int'(u_if.change),    1);
    chk("t1_busy_start",   int'(u_if.busy),      1);
    cyc(1);
    chk("t1_change_low",   int'(u_if.change),    0);
    chk("t1_count",        int'(u_if.press_count), 1);
    cyc(6);
    chk("t1_busy_last",    int'(u_if.busy),      1);
    cyc(1);
    chk("t1_busy_end",     int'(u_if.busy),      0);
    cyc(15);
    hold(1'b1, 20);
    chk("t1_pulses",       pulse_cnt - p0,       1);

    // 2. Bounce: 2-cycle toggles never reach 4 stable samples
    do_reset();
    p0 = pulse_cnt;
    for (int i = 0; i < 12; i++) begin
      u_if.key_in = ((i / 2) % 2) != 0;
      cyc(1);
    end
    chk("t2_level_bounce", int'(u_if.key_level), 0);
    chk("t2_no_pulse",     pulse_cnt - p0,       0);
    hold(1'b0, 30);
    hold(1'b1, 20);
    chk("t2_pulses",       pulse_cnt - p0,       1);
    chk("t2_count",        int'(u_if.press_count), 1);

    // 3. Release and short re-press inside the cooldown
    do_reset();
    p0 = pulse_cnt;
    hold(1'b0, 8);
    hold(1'b1, 6);
    hold(1'b0, 3);
    hold(1'b1, 30);
    chk("t3_pulses", pulse_cnt - p0,         1);
    chk("t3_count",  int'(u_if.press_count), 1);

    // 4. Held through cooldown, then release and a new press
    do_reset();
    p0 = pulse_cnt;
    hold(1'b0, 100);
    chk("t4_pulses_held", pulse_cnt - p0,    1);
    chk("t4_busy_off",    int'(u_if.busy),   0);
    hold(1'b1, 20);
    chk("t4_no_release_pulse", pulse_cnt - p0, 1);
    hold(1'b0, 20);
    hold(1'b1, 20);
    chk("t4_count", int'(u_if.press_count), 2);

    // 5. 256 presses wrap the counter
    do_reset();
    p0 = pulse_cnt;
    for (int i = 0; i < 256; i++) begin
      hold(1'b0, 14);
      hold(1'b1, 14);
    end
    chk("t5_pulses", pulse_cnt - p0,         256);
    chk("t5_count",  int'(u_if.press_count), 0);

    // 6. Reset during cooldown with the key still held
    do_reset();
    u_if.key_in = 1'b0;
    begin
      int n;
      n = 0;
      while (!u_if.busy && n < 50) begin
        cyc(1);
        n++;
      end
      chk("t6_busy_seen", int'(u_if.busy), 1);
    end
    cyc(2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_busy",      int'(u_if.busy),        0);
    chk("t6_rst_change",    int'(u_if.change),      0);
    chk("t6_rst_key_level", int'(u_if.key_level),   0);
    chk("t6_rst_count",     int'(u_if.press_count), 0);
    @(negedge clk);
    reset = 1'b0;
    p0 = pulse_cnt;
    cyc(25);
    chk("t6_pulses", pulse_cnt - p0,         1);
    chk("t6_count",  int'(u_if.press_count), 1);
    hold(1'b1, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/change_key_ctrl.md
Name: change_key_ctrl

Overview:
Front-end for the traffic light controller's `change` input. It takes a raw, bouncing push-button (DE2 KEY, asynchronous to clk) and converts it into a clean single-cycle `change` pulse for the phase-count logic. It synchronises, debounces, detects the press edge, and enforces a cooldown so that one physical press produces exactly one `change` pulse. It sits between the board pin and traffic_ctr.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles the synchronised key must be stable before key_level follows it (20 ms at 50 MHz); must be >= 1.
COOLDOWN_CYCLES, 25000000, cycles after a pulse during which new presses are ignored (0.5 s); must be >= 1.
CNT_W, 25, width of the debounce and cooldown counters; both cycle parameters must be < 2^CNT_W.
ACTIVE_LOW_KEY, 1, 1 = key_in reads 0 when pressed (DE2 KEYs); 0 = active-high.

Ports:
clk  input  1  50 MHz system clock
reset  input  1  synchronous, active-high reset
key_in  input  1  raw push-button, asynchronous, bouncing
change  output  1  single-cycle press pulse to traffic_ctr
key_level  output  1  debounced key state, 1 = pressed
busy  output  1  high while in cooldown
press_count  output  8  number of pulses issued, wraps 255->0

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - Synchroniser flops reset to the released level (1 if ACTIVE_LOW_KEY, else 0).
  - key_level=0, change=0, busy=0, press_count=0.
  - Both counters = 0; FSM in IDLE.
- Synchroniser: 2 flip-flops on key_in. Then normalise: pressed_raw = sync2 XOR ACTIVE_LOW_KEY.
- Debounce:
  - While pressed_raw != key_level, the debounce counter increments each cycle.
  - While they are equal, the counter clears to 0.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and still differs, key_level <= pressed_raw and the counter clears.
  - Any bounce back to equality before that edge restarts the count from 0.
- Latency from a clean key_in transition to key_level update: DEBOUNCE_CYCLES+2 edges (+1 for input sampling phase).
- Edge detect: key_level_d is key_level delayed one cycle. rise = key_level & ~key_level_d.
- FSM states:
  - IDLE: if rise, then at that edge change<=1, press_count<=press_count+1, cooldown counter<=COOLDOWN_CYCLES-1, next state COOLDOWN.
  - COOLDOWN: busy=1. The counter decrements each cycle. On the edge where counter==0: go to WAIT_RELEASE if key_level==1, else IDLE. rise events are ignored here.
  - WAIT_RELEASE: busy=0. Stay until key_level==0, then go to IDLE. No pulse is issued.
- Timing of outputs:
  - key_level rises at edge k => change is high for exactly the cycle between edges k+1 and k+2.
  - change is never high for two consecutive cycles.
  - busy is high for exactly COOLDOWN_CYCLES cycles, starting in the same cycle as change.
  - change, busy and key_level are all registered outputs.
- press_count is 8-bit modulo: 255 + 1 = 0.
- Boundary conditions:
  - A press released and re-pressed entirely within cooldown: ignored, no pulse.
  - A press still held when cooldown expires: WAIT_RELEASE, no pulse until release then a new press.
  - COOLDOWN_CYCLES=1: busy lasts one cycle; the next legal pulse requires a release and a new debounced press.
- Reset mid-operation (any state): returns to reset values on the next edge. If the key is still held after reset, it is treated as a new press: one pulse is issued after debounce completes.
- reset has priority over every other event in the same cycle.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8, ACTIVE_LOW_KEY=1.
1. Clean press: key_in 1->0 held for 30 cycles -> key_level rises 6-7 edges later. change pulses exactly once, 1 cycle wide, 1 cycle after key_level rises. busy is high for 8 cycles. press_count=1. FSM ends in WAIT_RELEASE.
2. Bounce: key_in toggles 0/1 every 2 cycles for 12 cycles, then holds 0 -> key_level stays 0 during the toggling and rises only after 4 stable cycles (+2 sync). Exactly one change pulse.
3. Press during cooldown: press, release after 8 cycles, re-press at cycle 14 (before busy drops) and release within cooldown -> only one change pulse; press_count=1.
4. Held through cooldown: hold key_in=0 for 100 cycles -> one pulse. busy drops after 8 cycles. No further pulse until release; after release and a new press, press_count=2.
5. Wrap: perform 256 full press/release cycles -> press_count returns to 0. change count equals 256.
6. Reset mid-cooldown: assert reset 3 cycles into busy while key is held -> next edge: busy=0, change=0, key_level=0, press_count=0. After reset deasserts with the key still held, one pulse follows after debounce.
